axi4lite_slave_if_mipi: RTL and testbench
=========================================

# axi4lite_slave_if_mipi

AXI4-Lite slave front end for the MIPI receive subsystem's control/status register space. Sits directly upstream of the register write decoder and register read mux. Converts AXI4-Lite write and read transactions into single-cycle memory-style strobes: mem_wr_valid/addr/data for writes, mem_rd_valid/addr for reads. Returns the read mux's data and the response codes to the bus master.

## Interface
- AXI_ADDR_WIDTH, 32, width of awaddr/araddr and of mem_wr_addr/mem_rd_addr
- AXI_DATA_WIDTH, 32, data width; only 32 is supported
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1  write-address handshake; awaddr  in  AXI_ADDR_WIDTH
- wvalid/wready  in/out  1  write-data handshake; wdata  in  32; wstrb  in  4
- bvalid  out  1, bready  in  1, bresp  out  2  write response
- arvalid/arready  in/out  1  read-address handshake; araddr  in  AXI_ADDR_WIDTH
- rvalid  out  1, rready  in  1, rdata  out  32, rresp  out  2  read response
- mem_wr_valid  out  1  one-cycle write strobe
- mem_wr_addr  out  AXI_ADDR_WIDTH  write address
- mem_wr_data  out  32  write data
- mem_rd_valid  out  1  one-cycle read strobe
- mem_rd_addr  out  AXI_ADDR_WIDTH  read address
- mem_rd_data  in  32  read data from the register mux, valid the cycle after mem_rd_valid
- awprot/arprot are not present and are tied off at the wrapper.

## Operation
- The write and read paths are independent FSMs and may run concurrently. The downstream write decoder and read mux have no shared resource.
- Write FSM states: W_IDLE, W_EXEC, W_RESP.
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in either order or in the same cycle. Each is latched into a holding register on its handshake.
  - When both are latched, go to W_EXEC.
  - W_EXEC (one cycle): if wstrb==4'hF, mem_wr_valid=1 with the latched addr/data and bresp=2'b00. Otherwise mem_wr_valid stays 0 and bresp=2'b10 (SLVERR); partial writes are rejected, not merged.
  - W_RESP: bvalid=1 and bresp held until bready. Then go to W_IDLE, clearing both captured flags.
- Read FSM states: R_IDLE, R_EXEC, R_WAIT, R_RESP.
  - R_IDLE: arready=1; on arvalid, latch araddr and go to R_EXEC.
  - R_EXEC (one cycle): mem_rd_valid=1 and mem_rd_addr=latched address.
  - R_WAIT (one cycle): capture mem_rd_data into rdata.
  - R_RESP: rvalid=1, rresp=2'b00, rdata stable until rready. Then go to R_IDLE.
- All address bits pass through unmodified. Decoding and alignment belong to the downstream blocks.
- mem_wr_addr/mem_wr_data hold their last value when mem_wr_valid=0. The same holds for mem_rd_addr.
- Only one outstanding transaction per channel. awready/wready/arready are deasserted outside the idle states.

## Timing
- Reset value of every output is 0: all ready/valid signals, bresp, rresp, rdata, and all mem_* outputs. FSMs reset to W_IDLE/R_IDLE.
- All outputs are registered or decoded from state registers. There is no combinational path from any AXI input to any AXI output.
- Write latency: last of AW/W handshakes at edge N → mem_wr_valid high in cycle N+1 → bvalid high from cycle N+2.
  - Minimum write throughput: one transaction per 3 cycles with bready held high.
- Read latency: AR handshake at edge N → mem_rd_valid in cycle N+1 → data captured at the end of cycle N+2 → rvalid from cycle N+3.
- A valid signal asserted while the corresponding ready is low is held off with no loss. Backpressure on bready/rready stalls only its own FSM.
- Reset asserted mid-transaction aborts it immediately:
  - No mem_wr_valid or mem_rd_valid is issued afterwards.
  - bvalid and rvalid drop asynchronously.

## Test plan
- AW then W two cycles later, awaddr=0x08, wdata=0xA5A5_0001, wstrb=F → exactly one mem_wr_valid pulse with addr 0x08/data 0xA5A5_0001, then bvalid with bresp=00.
- W before AW, and a separate case with AW+W in the same cycle → identical single mem_wr_valid pulse; no second write.
- wstrb=4'h3 → no mem_wr_valid pulse; bresp=2'b10.
- Read araddr=0x0C with mem_rd_data=0x0000_0003 driven the cycle after mem_rd_valid → rvalid 3 cycles after the AR handshake, rdata=0x3, rresp=00.
- bready held low for 10 cycles with a concurrent read → bvalid is held for all 10 cycles and bresp stays stable; the read completes normally; no new AW is accepted until B completes.
- aresetn pulsed low while in W_EXEC-1 (both AW and W captured) → no mem_wr_valid; all outputs are 0; the next transaction completes normally.

Source files
------------

// File: rtl/axi4lite_slave_if_mipi.sv
// AXI4-Lite slave front end for the MIPI RX control/status register space.
// Latency: write strobe 1 cycle after the last AW/W handshake, B one cycle later;
//          read strobe 1 cycle after AR, R valid 3 cycles after AR.
// Backpressure: one outstanding transaction per channel; bready/rready stall only
//          their own FSM, and a valid seen while ready is low is simply held off.
//
// Ports:
//   aclk, aresetn              clock, asynchronous active-low reset
//   aw*/w*/b*                  AXI4-Lite write address, write data, write response
//   ar*/r*                     AXI4-Lite read address, read data/response
//   mem_wr_valid/addr/data     single-cycle write strobe to the register decoder
//   mem_rd_valid/addr          single-cycle read strobe to the register read mux
//   mem_rd_data                read mux data, valid the cycle after mem_rd_valid
//
// Every output comes straight from a flop (rresp is a constant), so there is
// no combinational path from any AXI input to any AXI output.

module axi4lite_slave_if_mipi #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,

  // write address channel
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   awaddr,

  // write data channel
  input  logic                        wvalid,
  output logic                        wready,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,

  // write response channel
  output logic                        bvalid,
  input  logic                        bready,
  output logic [1:0]                  bresp,

  // read address channel
  input  logic                        arvalid,
  output logic                        arready,
  input  logic [AXI_ADDR_WIDTH-1:0]   araddr,

  // read data channel
  output logic                        rvalid,
  input  logic                        rready,
  output logic [AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                  rresp,

  // register-side strobes
  output logic                        mem_wr_valid,
  output logic [AXI_ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wr_data,
  output logic                        mem_rd_valid,
  output logic [AXI_ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_rd_data
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_EXEC = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } r_state_e;

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  w_state_e                  w_state_q,      w_state_d;
  logic                      aw_cap_q,       aw_cap_d;
  logic                      w_cap_q,        w_cap_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q,      aw_addr_d;
  logic [AXI_DATA_WIDTH-1:0] w_data_q,       w_data_d;
  logic [STRB_W-1:0]         w_strb_q,       w_strb_d;
  logic                      awready_q,      awready_d;
  logic                      wready_q,       wready_d;
  logic                      bvalid_q,       bvalid_d;
  logic [1:0]                bresp_q,        bresp_d;
  logic                      mem_wr_valid_q, mem_wr_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] mem_wr_addr_q,  mem_wr_addr_d;
  logic [AXI_DATA_WIDTH-1:0] mem_wr_data_q,  mem_wr_data_d;

  // ---------------------------------------------------------------------------
  // Read path state
  // ---------------------------------------------------------------------------
  r_state_e                  r_state_q,      r_state_d;
  logic                      arready_q,      arready_d;
  logic                      rvalid_q,       rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q,        rdata_d;
  logic                      mem_rd_valid_q, mem_rd_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] mem_rd_addr_q,  mem_rd_addr_d;

  // ---------------------------------------------------------------------------
  // Write FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d      = w_state_q;
    aw_cap_d       = aw_cap_q;
    w_cap_d        = w_cap_q;
    aw_addr_d      = aw_addr_q;
    w_data_d       = w_data_q;
    w_strb_d       = w_strb_q;
    bresp_d        = bresp_q;
    mem_wr_valid_d = 1'b0;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;

    case (w_state_q)
      W_IDLE: begin
        // AW and W are captured independently; either may come first.
        if (awvalid && awready_q) begin
          aw_cap_d  = 1'b1;
          aw_addr_d = awaddr;
        end
        if (wvalid && wready_q) begin
          w_cap_d  = 1'b1;
          w_data_d = wdata;
          w_strb_d = wstrb;
        end
        // The strobe flop is loaded on the same edge that enters W_EXEC so
        // that mem_wr_valid is high exactly during the W_EXEC cycle. The
        // _d values cover the case where the last handshake is this edge.
        if (aw_cap_d && w_cap_d) begin
          w_state_d = W_EXEC;
          if (&w_strb_d) begin
            mem_wr_valid_d = 1'b1;
            mem_wr_addr_d  = aw_addr_d;
            mem_wr_data_d  = w_data_d;
          end
        end
      end

      W_EXEC: begin
        // Partial writes are rejected outright rather than merged.
        w_state_d = W_RESP;
        bresp_d   = (&w_strb_q) ? RESP_OKAY : RESP_SLVERR;
      end

      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          aw_cap_d  = 1'b0;
          w_cap_d   = 1'b0;
        end
      end

      default: begin
        w_state_d = W_IDLE;
        aw_cap_d  = 1'b0;
        w_cap_d   = 1'b0;
      end
    endcase

    // Readies are decoded from the next state so they are registered yet
    // drop on the very edge that completes the capture.
    awready_d = (w_state_d == W_IDLE) && !aw_cap_d;
    wready_d  = (w_state_d == W_IDLE) && !w_cap_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q      <= W_IDLE;
      aw_cap_q       <= 1'b0;
      w_cap_q        <= 1'b0;
      aw_addr_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      awready_q      <= 1'b0;
      wready_q       <= 1'b0;
      bvalid_q       <= 1'b0;
      bresp_q        <= 2'b00;
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
    end else begin
      w_state_q      <= w_state_d;
      aw_cap_q       <= aw_cap_d;
      w_cap_q        <= w_cap_d;
      aw_addr_q      <= aw_addr_d;
      w_data_q       <= w_data_d;
      w_strb_q       <= w_strb_d;
      awready_q      <= awready_d;
      wready_q       <= wready_d;
      bvalid_q       <= bvalid_d;
      bresp_q        <= bresp_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    r_state_d      = r_state_q;
    rdata_d        = rdata_q;
    mem_rd_valid_d = 1'b0;
    mem_rd_addr_d  = mem_rd_addr_q;

    case (r_state_q)
      R_IDLE: begin
        // The address is latched straight into the strobe address flop; it
        // only changes on the edge that raises mem_rd_valid, so it still
        // holds its last value whenever mem_rd_valid is low.
        if (arvalid && arready_q) begin
          r_state_d      = R_EXEC;
          mem_rd_valid_d = 1'b1;
          mem_rd_addr_d  = araddr;
        end
      end

      R_EXEC: begin
        r_state_d = R_WAIT;
      end

      R_WAIT: begin
        // The read mux presents its data one cycle after the strobe.
        r_state_d = R_RESP;
        rdata_d   = mem_rd_data;
      end

      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
        end
      end

      default: begin
        r_state_d = R_IDLE;
      end
    endcase

    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q      <= R_IDLE;
      arready_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      mem_rd_valid_q <= 1'b0;
      mem_rd_addr_q  <= '0;
    end else begin
      r_state_q      <= r_state_d;
      arready_q      <= arready_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign arready      = arready_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  // Reads cannot fail at this level; address decode errors are not reported.
  assign rresp        = RESP_OKAY;
  assign mem_wr_valid = mem_wr_valid_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_rd_valid = mem_rd_valid_q;
  assign mem_rd_addr  = mem_rd_addr_q;

endmodule

// File: tb/tb_axi4lite_slave_if_mipi.sv
// Directed bench for axi4lite_slave_if_mipi with a transaction-level model.
// The model tracks captured AW/W/AR by cycle number and derives every output.
// Directed tasks add hand-computed literal expectations on top.

module tb_axi4lite_slave_if_mipi;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = '0;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;

  always #5 aclk = ~aclk;

  axi4lite_slave_if_mipi #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data the register mux returns for a given address.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0000_0003;
    return a ^ 32'hC0DE_0000;
  endfunction

  // ---------------------------------------------------------------------------
  // Model: cyc counts clock edges since reset release; the cycle following
  // edge c is "cycle c". wcap/arcap record the cycle in which the write was
  // fully captured / the read address was taken (-1 when none outstanding).
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          wcap = -1;
  int          arcap = -1;
  bit          have_aw = 0, have_w = 0, m_full = 0;
  logic [31:0] m_awaddr = '0, m_wdata = '0, m_araddr = '0;
  logic [3:0]  m_wstrb = '0;

  logic        exp_awready = 0, exp_wready = 0, exp_arready = 0;
  logic        exp_bvalid = 0, exp_rvalid = 0;
  logic [1:0]  exp_bresp = '0;
  logic [31:0] exp_rdata = '0;
  logic        exp_mem_wr_valid = 0, exp_mem_rd_valid = 0;
  logic [31:0] exp_mem_wr_addr = '0, exp_mem_wr_data = '0, exp_mem_rd_addr = '0;

  initial forever begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    @(posedge aclk or negedge aresetn);
    if (!aresetn) begin
      cyc = 0; wcap = -1; arcap = -1;
      have_aw = 0; have_w = 0; m_full = 0;
      exp_awready = 0; exp_wready = 0; exp_arready = 0;
      exp_bvalid = 0; exp_rvalid = 0; exp_bresp = '0; exp_rdata = '0;
      exp_mem_wr_valid = 0; exp_mem_rd_valid = 0;
      exp_mem_wr_addr = '0; exp_mem_wr_data = '0; exp_mem_rd_addr = '0;
    end else begin
      cyc++;
      aw_hs = awvalid && exp_awready;
      w_hs  = wvalid  && exp_wready;
      b_hs  = exp_bvalid && bready;
      ar_hs = arvalid && exp_arready;
      r_hs  = exp_rvalid && rready;

      if (aw_hs) begin have_aw = 1; m_awaddr = awaddr; end
      if (w_hs)  begin have_w = 1; m_wdata = wdata; m_wstrb = wstrb; end
      if (wcap < 0 && have_aw && have_w) begin
        wcap   = cyc;
        m_full = (m_wstrb == 4'hF);
      end
      if (b_hs) begin wcap = -1; have_aw = 0; have_w = 0; end

      if (ar_hs) begin arcap = cyc; m_araddr = araddr; end
      if (arcap >= 0 && cyc == arcap + 2) exp_rdata = rd_val(m_araddr);
      if (r_hs) arcap = -1;

      exp_mem_wr_valid = (wcap == cyc) && m_full;
      if (exp_mem_wr_valid) begin
        exp_mem_wr_addr = m_awaddr;
        exp_mem_wr_data = m_wdata;
      end
      exp_bvalid = (wcap >= 0) && (cyc > wcap);
      if (wcap >= 0 && cyc == wcap + 1) exp_bresp = m_full ? 2'b00 : 2'b10;
      exp_awready = (wcap < 0) && !have_aw;
      exp_wready  = (wcap < 0) && !have_w;

      exp_mem_rd_valid = (arcap == cyc);
      if (exp_mem_rd_valid) exp_mem_rd_addr = m_araddr;
      exp_rvalid  = (arcap >= 0) && (cyc >= arcap + 2);
      exp_arready = (arcap < 0);
    end
  end

  // Register mux stand-in: real data only in the cycle after the strobe.
  initial forever begin
    @(negedge aclk);
    if (arcap >= 0 && cyc == arcap + 1) mem_rd_data = rd_val(m_araddr);
    else                                mem_rd_data = $urandom;
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge aclk);
    chk("awready",      awready,      exp_awready);
    chk("wready",       wready,       exp_wready);
    chk("bvalid",       bvalid,       exp_bvalid);
    chk("bresp",        bresp,        exp_bresp);
    chk("arready",      arready,      exp_arready);
    chk("rvalid",       rvalid,       exp_rvalid);
    chk("rdata",        rdata,        exp_rdata);
    chk("rresp",        rresp,        2'b00);
    chk("mem_wr_valid", mem_wr_valid, exp_mem_wr_valid);
    chk("mem_wr_addr",  mem_wr_addr,  exp_mem_wr_addr);
    chk("mem_wr_data",  mem_wr_data,  exp_mem_wr_data);
    chk("mem_rd_valid", mem_rd_valid, exp_mem_rd_valid);
    chk("mem_rd_addr",  mem_rd_addr,  exp_mem_rd_addr);
  end

  // Pulse monitor for the directed literal checks.
  int          wr_pulses = 0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0;
  logic [1:0]  last_bresp = '0;
  initial forever begin
    @(negedge aclk);
    #1;
    if (mem_wr_valid === 1'b1) begin
      wr_pulses++;
      last_wr_addr = mem_wr_addr;
      last_wr_data = mem_wr_data;
    end
    if (bvalid === 1'b1) last_bresp = bresp;
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks: all called and returning at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic send_aw(input logic [31:0] a);
    bit seen = 0;
    awvalid = 1; awaddr = a;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (awready) seen = 1;
      @(negedge aclk);
    end
    awvalid = 0;
    chk("aw_handshake", seen, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit seen = 0;
    wvalid = 1; wdata = d; wstrb = s;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (wready) seen = 1;
      @(negedge aclk);
    end
    wvalid = 0;
    chk("w_handshake", seen, 1);
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit seen = 0;
    arvalid = 1; araddr = a;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (arready) seen = 1;
      @(negedge aclk);
    end
    arvalid = 0;
    chk("ar_handshake", seen, 1);
  endtask

  task automatic wait_b();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bvalid && bready) seen = 1;
      @(negedge aclk);
    end
    chk("b_handshake", seen, 1);
  endtask

  task automatic wait_r();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rvalid && rready) seen = 1;
      @(negedge aclk);
    end
    chk("r_handshake", seen, 1);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
    fork
      begin repeat (aw_dly) @(negedge aclk); send_aw(a); end
      begin repeat (w_dly)  @(negedge aclk); send_w(d, s); end
    join
    wait_b();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n0, k, hold;
    #1 aresetn = 0;
    repeat (3) @(negedge aclk);
    chk("rst_awready", awready, 0);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_rdata",   rdata,   0);
    chk("rst_mem_wr_addr", mem_wr_addr, 0);
    aresetn = 1;
    @(negedge aclk);
    chk("post_rst_awready", awready, 1);
    chk("post_rst_arready", arready, 1);

    // AW first, W two cycles later.
    n0 = wr_pulses;
    send_write(32'h08, 32'hA5A5_0001, 4'hF, 0, 2);
    @(negedge aclk);
    chk("t1_pulses", wr_pulses - n0, 1);
    chk("t1_addr",   last_wr_addr, 32'h08);
    chk("t1_data",   last_wr_data, 32'hA5A5_0001);
    chk("t1_bresp",  last_bresp, 2'b00);

    // W before AW.
    n0 = wr_pulses;
    send_write(32'h14, 32'h0BAD_F00D, 4'hF, 3, 0);
    @(negedge aclk);
    chk("t2a_pulses", wr_pulses - n0, 1);
    chk("t2a_addr",   last_wr_addr, 32'h14);
    chk("t2a_data",   last_wr_data, 32'h0BAD_F00D);

    // AW and W in the same cycle.
    n0 = wr_pulses;
    send_write(32'h18, 32'h1111_2222, 4'hF, 0, 0);
    @(negedge aclk);
    chk("t2b_pulses", wr_pulses - n0, 1);
    chk("t2b_addr",   last_wr_addr, 32'h18);

    // Partial strobe is rejected.
    n0 = wr_pulses;
    send_write(32'h1C, 32'hDEAD_BEEF, 4'h3, 0, 0);
    @(negedge aclk);
    chk("t3_pulses",    wr_pulses - n0, 0);
    chk("t3_bresp",     last_bresp, 2'b10);
    chk("t3_hold_addr", mem_wr_addr, 32'h18);

    // Read of 0x0C.
    send_ar(32'h0C);
    chk("t4_rd_valid", mem_rd_valid, 1);
    chk("t4_rd_addr",  mem_rd_addr, 32'h0C);
    k = 0;
    while (!rvalid && k < 20) begin @(negedge aclk); k++; end
    chk("t4_latency", k + 1, 3);
    chk("t4_rdata",   rdata, 32'h3);
    wait_r();

    // bready held low for 10 cycles with a concurrent read.
    n0 = wr_pulses;
    bready = 0;
    fork
      begin
        fork
          send_aw(32'h20);
          send_w(32'h1234_5678, 4'hF);
        join
        k = 0;
        while (!bvalid && k < 10) begin @(negedge aclk); k++; end
        awvalid = 1; awaddr = 32'h40;
        hold = 0;
        for (int i = 0; i < 10; i++) begin
          if (bvalid) hold++;
          chk("t5_no_new_aw", awready, 0);
          @(negedge aclk);
        end
        chk("t5_bvalid_held", hold, 10);
        awvalid = 0;
        bready = 1;
        wait_b();
        send_write(32'h40, 32'h9999_0000, 4'hF, 0, 0);
      end
      begin
        send_ar(32'h24);
        wait_r();
      end
    join
    @(negedge aclk);
    chk("t5_pulses", wr_pulses - n0, 2);
    chk("t5_addr",   last_wr_addr, 32'h40);

    // Reset pulsed with AW captured and W on the bus.
    n0 = wr_pulses;
    send_aw(32'h30);
    wvalid = 1; wdata = 32'h7777_7777; wstrb = 4'hF;
    #2 aresetn = 0;
    @(negedge aclk);
    wvalid = 0;
    chk("t6_mem_wr_valid", mem_wr_valid, 0);
    chk("t6_bvalid",       bvalid, 0);
    chk("t6_wready",       wready, 0);
    #2 aresetn = 1;
    repeat (2) @(negedge aclk);
    chk("t6_no_pulse", wr_pulses - n0, 0);
    send_write(32'h34, 32'h5555_AAAA, 4'hF, 0, 0);
    @(negedge aclk);
    chk("t6_pulses", wr_pulses - n0, 1);
    chk("t6_addr",   last_wr_addr, 32'h34);

    // Reset while both B and R are stalled: valids drop without a clock edge.
    bready = 0; rready = 0;
    fork
      send_aw(32'h50);
      send_w(32'h0000_0001, 4'hF);
      send_ar(32'h54);
    join
    repeat (4) @(negedge aclk);
    chk("t7_bvalid_pre", bvalid, 1);
    chk("t7_rvalid_pre", rvalid, 1);
    #2 aresetn = 0;
    #1;
    chk("t7_bvalid_async", bvalid, 0);
    chk("t7_rvalid_async", rvalid, 0);
    chk("t7_mem_wr_addr",  mem_wr_addr, 0);
    bready = 1; rready = 1;
    @(negedge aclk);
    #2 aresetn = 1;
    @(negedge aclk);

    // Recovery after reset.
    send_write(32'h60, 32'hCAFE_0060, 4'hF, 1, 0);
    send_ar(32'h60);
    wait_r();
    chk("t8_rdata", rdata, 32'hC0DE_0060);

    repeat (3) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
